// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      WAIT_DONE  = 2'd2
   } arb_state_t;

   // Ceiling log2, used to size the requester index and the timeout counter.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: rotate requests down by the pointer,
// take the lowest set bit, rotate the result back up.
module uart_rr_pick #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic [ID_WIDTH-1:0] i_ptr,
   output logic [NUM_REQ-1:0]  o_onehot_c,
   output logic [ID_WIDTH-1:0] o_idx_c,
   output logic                o_found_c
);

   localparam int unsigned SUM_W = ID_WIDTH + 1;

   logic [NUM_REQ-1:0]  w_rot;
   logic [ID_WIDTH-1:0] w_off;
   logic [SUM_W-1:0]    w_sum;

   // Rotate so the pointer position becomes bit 0.
   assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

   // Lowest set bit of the rotated vector is the winner's offset from the pointer.
   always_comb begin
      w_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = ID_WIDTH'(i);
         end
      end
   end

   // Rotate back: winner index = (pointer + offset) mod NUM_REQ.
   always_comb begin
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= SUM_W'(NUM_REQ)) begin
         w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      o_idx_c    = w_sum[ID_WIDTH-1:0];
      o_found_c  = |i_req;
      o_onehot_c = o_found_c ? (NUM_REQ'(1) << o_idx_c) : '0;
   end

endmodule : uart_rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Launches one byte with a single-cycle valid, then follows the TX busy flag
// through the frame (or drops it if busy never rises) before serving the next.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_WIDTH     = 2,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [DATA_WIDTH-1:0]         o_tx_p_data,
   output logic                          o_tx_data_valid,
   input  logic                          i_tx_busy,
   output logic [ID_WIDTH-1:0]           o_active_id,
   output logic                          o_arb_busy,
   output logic                          o_timeout_err
);

   localparam int unsigned CNT_W = clog2(BUSY_TIMEOUT) + 1;

   if (ID_WIDTH != clog2(NUM_REQ)) begin : g_bad_id_width
      $error("uart_tx_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
   end
   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be at least 2");
   end

   arb_state_t            r_state, w_state_n;
   logic [CNT_W-1:0]      r_cnt, w_cnt_n;
   logic [ID_WIDTH-1:0]   r_ptr, w_ptr_n;
   logic [NUM_REQ-1:0]    r_gnt, w_gnt_n;
   logic                  r_valid, w_valid_n;
   logic [DATA_WIDTH-1:0] r_data, w_data_n;
   logic [ID_WIDTH-1:0]   r_id, w_id_n;
   logic                  r_timeout, w_timeout_n;
   logic                  r_arb_busy, w_arb_busy_n;

   logic [NUM_REQ-1:0]    w_onehot;
   logic [ID_WIDTH-1:0]   w_idx;
   logic                  w_found;

   uart_rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .i_req      (i_req),
      .i_ptr      (r_ptr),
      .o_onehot_c (w_onehot),
      .o_idx_c    (w_idx),
      .o_found_c  (w_found)
   );

   // Next-state and next-output logic; outputs not assigned below are pulses or hold.
   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_ptr_n     = r_ptr;
      w_gnt_n     = '0;
      w_valid_n   = 1'b0;
      w_data_n    = r_data;
      w_id_n      = r_id;
      w_timeout_n = 1'b0;

      case (r_state)
         IDLE: begin
            // A busy UART in IDLE is a frame still in flight from before a reset.
            if (w_found && !i_tx_busy) begin
               w_gnt_n   = w_onehot;
               w_valid_n = 1'b1;
               w_id_n    = w_idx;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (w_idx == ID_WIDTH'(i)) begin
                     w_data_n = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
               w_ptr_n   = (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
               w_cnt_n   = '0;
               w_state_n = WAIT_START;
            end
         end
         WAIT_START: begin
            w_cnt_n = r_cnt + 1'b1;
            if (i_tx_busy) begin
               w_state_n = WAIT_DONE;
            end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               // Busy never rose: drop the frame without retry.
               w_timeout_n = 1'b1;
               w_state_n   = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!i_tx_busy) begin
               w_state_n = IDLE;
            end
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase

      w_arb_busy_n = (w_state_n != IDLE);
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_id       <= '0;
         r_timeout  <= 1'b0;
         r_arb_busy <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_ptr      <= w_ptr_n;
         r_gnt      <= w_gnt_n;
         r_valid    <= w_valid_n;
         r_data     <= w_data_n;
         r_id       <= w_id_n;
         r_timeout  <= w_timeout_n;
         r_arb_busy <= w_arb_busy_n;
      end
   end

   assign o_gnt           = r_gnt;
   assign o_tx_data_valid = r_valid;
   assign o_tx_p_data     = r_data;
   assign o_active_id     = r_id;
   assign o_timeout_err   = r_timeout;
   assign o_arb_busy      = r_arb_busy;

endmodule : uart_tx_arbiter
